// File: rtl/serial_load_sequencer.sv
// Replays ioctl download bytes as 8N1 frames on the ACIA rxd line, muxed with uart_rxd (SERIAL_LOAD_LF_STRIP_EN drops 0x0A on write).
// Latency: pop 1 cycle after write, start bit 2 cycles after; ioctl_wait raised at FIFO_DEPTH-2, writes to a full FIFO are dropped and flagged.
module serial_load_sequencer #(
    parameter int CLK_HZ     = 48000000,
    parameter int FIFO_DEPTH = 16,
    parameter int GAP_CHARS  = 4
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ioctl_download,
    input  logic       ioctl_wr,
    input  logic [7:0] ioctl_data,
    output logic       ioctl_wait,
    input  logic       load_from,
    input  logic       baud_rate,
    input  logic       uart_rxd,
    output logic       rxd_out,
    output logic       busy,
    output logic       overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [17:0] DIV_FAST = 18'(CLK_HZ / 9600);
    localparam logic [17:0] DIV_SLOW = 18'(CLK_HZ / 300);
    localparam int GAP_BITS = GAP_CHARS * 10;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;
    state_t state, state_nxt;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nxt;
    logic [17:0]   div_q, bit_cnt;
    logic [15:0]   bit_idx;
    logic [7:0]    byte_q;
    logic          load_q, sel_file, dl_q;
    logic          wr_req, wr_en, rd_en, bit_end, line;

`ifdef SERIAL_LOAD_LF_STRIP_EN
    assign wr_req = ioctl_wr && ioctl_download && (ioctl_data != 8'h0A);
`else
    assign wr_req = ioctl_wr && ioctl_download;
`endif
    assign wr_en   = wr_req && (count < CW'(FIFO_DEPTH));
    assign bit_end = (bit_cnt == div_q - 18'd1);

    always_comb begin
        count_nxt = count;
        case ({wr_en, rd_en})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Source select is only re-evaluated in IDLE, so a frame is never cut short.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        line      = 1'b1;
        case (state)
            IDLE: begin
                if (!load_q && count != '0) begin
                    rd_en     = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                line = 1'b0;
                if (bit_end) state_nxt = DATA;
            end
            DATA: begin
                line = byte_q[bit_idx[2:0]];
                if (bit_end && bit_idx == 16'd7) state_nxt = STOP;
            end
            STOP: begin
                if (bit_end)
                    state_nxt = (byte_q == 8'h0D && GAP_CHARS > 0) ? GAP : IDLE;
            end
            GAP: begin
                if (bit_end && bit_idx == 16'(GAP_BITS - 1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (wr_en) mem[wr_ptr] <= ioctl_data;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            div_q      <= DIV_FAST;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            byte_q     <= '0;
            load_q     <= 1'b0;
            sel_file   <= 1'b1;
            dl_q       <= 1'b0;
            rxd_out    <= 1'b1;
            ioctl_wait <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            load_q <= load_from;
            dl_q   <= ioctl_download;
            count  <= count_nxt;
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) begin
                byte_q <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
                div_q  <= baud_rate ? DIV_SLOW : DIV_FAST;
            end

            if (state == IDLE) begin
                sel_file <= !load_q;
                bit_cnt  <= '0;
                bit_idx  <= '0;
            end else begin
                bit_cnt <= bit_end ? 18'd0 : bit_cnt + 18'd1;
                if (state_nxt != state)
                    bit_idx <= '0;
                else if (bit_end && (state == DATA || state == GAP))
                    bit_idx <= bit_idx + 16'd1;
            end

            rxd_out    <= sel_file ? line : uart_rxd;
            busy       <= (count != '0) || (state != IDLE);
            // Raised two slots early so a write already in flight still lands.
            ioctl_wait <= (count_nxt >= CW'(FIFO_DEPTH - 2));

            if (wr_req && !wr_en)
                overflow <= 1'b1;
            else if (ioctl_download && !dl_q)
                overflow <= 1'b0;
        end
    end
endmodule
